// File: rtl/mainboard_wb_arbiter_if.sv
// rtl/mainboard_wb_arbiter_if.sv - Wishbone-style point-to-point bus bundle used on both sides of the arbiter
interface mainboard_wb_arbiter_if;
    logic [0:23] adr;
    logic [7:0]  dat_w;
    logic [7:0]  dat_r;
    logic        we;
    logic [0:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack, err
    );
endinterface

// File: rtl/mainboard_wb_arbiter.sv
// rtl/mainboard_wb_arbiter.sv - two-master Wishbone arbiter with bus lock, fair contention and stall timeout
module mainboard_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FIRST_MASTER   = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    mainboard_wb_arbiter_if.slave         m0,
    mainboard_wb_arbiter_if.slave         m1,
    mainboard_wb_arbiter_if.master        s
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [15:0] STALL_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        LAST_OWNER_RST = (FIRST_MASTER == 0) ? 1'b1 : 1'b0;

    state_e      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        abort_q, abort_d;

    logic        own0;
    logic        own1;
    logic        s_stb;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    always_comb begin : slave_mux
        s.adr   = '0;
        s.dat_w = 8'h00;
        s.we    = 1'b0;
        s.sel   = 1'b0;
        s.cyc   = 1'b0;
        s_stb   = 1'b0;
        if (own0) begin
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.we    = m0.we;
            s.sel   = m0.sel;
            s.cyc   = m0.cyc;
            s_stb   = m0.stb & ~abort_q;
        end else if (own1) begin
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.we    = m1.we;
            s.sel   = m1.sel;
            s.cyc   = m1.cyc;
            s_stb   = m1.stb & ~abort_q;
        end
    end

    assign s.stb = s_stb;

    // s_stb is already forced low during abort, so a late slave ack cannot reach the master
    assign m0.ack   = s.ack & own0 & s_stb;
    assign m1.ack   = s.ack & own1 & s_stb;
    assign m0.err   = abort_q & own0;
    assign m1.err   = abort_q & own1;
    assign m0.dat_r = own0 ? s.dat_r : 8'h00;
    assign m1.dat_r = own1 ? s.dat_r : 8'h00;

    always_comb begin : next_owner
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    if (last_owner_q) begin
                        state_d      = OWN0;
                        last_owner_d = 1'b0;
                    end else begin
                        state_d      = OWN1;
                        last_owner_d = 1'b1;
                    end
                end else if (m0.cyc) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                end else if (m1.cyc) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                end
            end
            OWN0: begin
                if (!m0.cyc) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!m1.cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin : stall_watch
        stall_cnt_d = (!s_stb || s.ack) ? 16'd0 : stall_cnt_q + 16'd1;
        abort_d     = s_stb && !s.ack && (stall_cnt_q == STALL_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= LAST_OWNER_RST;
            stall_cnt_q  <= 16'd0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            stall_cnt_q  <= stall_cnt_d;
            abort_q      <= abort_d;
        end
    end
endmodule

// File: tb/tb_mainboard_wb_arbiter.sv
// tb/tb_mainboard_wb_arbiter.sv - scoreboard bench for the two-master Wishbone arbiter
module tb_mainboard_wb_arbiter;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        int         mst;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];

    mainboard_wb_arbiter_if m0_if ();
    mainboard_wb_arbiter_if m1_if ();
    mainboard_wb_arbiter_if s_if ();

    mainboard_wb_arbiter #(
        .TIMEOUT_CYCLES (4),
        .FIRST_MASTER   (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [0:23] adr, input logic [7:0] dat);
        if (m == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.adr = adr; m0_if.dat_w = dat; m0_if.sel = 1'b1;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.adr = adr; m1_if.dat_w = dat; m1_if.sel = 1'b1;
        end
    endtask

    task automatic set_stb(input int m, input logic v);
        if (m == 0) m0_if.stb = v; else m1_if.stb = v;
    endtask

    task automatic set_cyc(input int m, input logic v);
        if (m == 0) m0_if.cyc = v; else m1_if.cyc = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_if.ack : m1_if.ack;
    endfunction

    function automatic logic get_err(input int m);
        return (m == 0) ? m0_if.err : m1_if.err;
    endfunction

    function automatic logic [7:0] get_dat(input int m);
        return (m == 0) ? m0_if.dat_r : m1_if.dat_r;
    endfunction

    // Called just after a rising edge; slave acks 'delay' cycles after s_stb first rises.
    task automatic xfer(input int m, input logic we, input logic [0:23] adr, input logic [7:0] wd,
                        input logic [7:0] rd, input int delay, input int exp_lat);
        exp_t e;
        int   lat;
        int   stall;
        bit   done;
        drive_m(m, 1'b1, 1'b1, we, adr, wd);
        sb.push_back('{mst: m, dat: rd});
        lat = 0; stall = 0; done = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            @(negedge clk);
            if (s_if.stb !== 1'b1) begin
                lat++;
            end else begin
                if (stall == 0) begin
                    checks++;
                    if (lat != exp_lat) begin
                        errors++;
                        $display("FAIL grant_latency m%0d: got %0d cycles, required %0d", m, lat, exp_lat);
                    end
                    checks++;
                    if (s_if.cyc !== 1'b1 || s_if.we !== we || s_if.adr !== adr || s_if.dat_w !== wd) begin
                        errors++;
                        $display("FAIL slave_fwd m%0d: got cyc=%b we=%b adr=%h dat=%h, required cyc=1 we=%b adr=%h dat=%h",
                                 m, s_if.cyc, s_if.we, s_if.adr, s_if.dat_w, we, adr, wd);
                    end
                end
                if (stall == delay) begin
                    s_if.ack = 1'b1;
                    s_if.dat_r = rd;
                    #1;
                    e = sb.pop_front();
                    checks++;
                    if (get_ack(e.mst) !== 1'b1 || get_err(e.mst) !== 1'b0) begin
                        errors++;
                        $display("FAIL ack m%0d: got ack=%b err=%b, required ack=1 err=0",
                                 e.mst, get_ack(e.mst), get_err(e.mst));
                    end
                    checks++;
                    if (get_dat(e.mst) !== e.dat) begin
                        errors++;
                        $display("FAIL rdata m%0d: got %h, required %h", e.mst, get_dat(e.mst), e.dat);
                    end
                    checks++;
                    if (get_ack(1 - e.mst) !== 1'b0 || get_dat(1 - e.mst) !== 8'h00) begin
                        errors++;
                        $display("FAIL other_master m%0d: got ack=%b dat=%h, required ack=0 dat=00",
                                 1 - e.mst, get_ack(1 - e.mst), get_dat(1 - e.mst));
                    end
                    done = 1'b1;
                end else begin
                    checks++;
                    if (get_ack(m) !== 1'b0) begin
                        errors++;
                        $display("FAIL early_ack m%0d: got ack=%b before slave ack, required 0", m, get_ack(m));
                    end
                end
                stall++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout m%0d: got no grant/ack within 32 cycles, required completion", m);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        s_if.ack = 1'b0;
        s_if.dat_r = 8'hA5;
        set_stb(m, 1'b0);
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        s_if.dat_r = 8'hFF;
        s_if.ack = 1'b1;
        drive_m(0, 1'b1, 1'b1, 1'b1, 24'h123456, 8'h99);
        #12;
        checks++;
        if ({s_if.cyc, s_if.stb, s_if.we, s_if.sel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_slave_ctl: got %b, required 0000", {s_if.cyc, s_if.stb, s_if.we, s_if.sel});
        end
        checks++;
        if (s_if.adr !== 24'h000000 || s_if.dat_w !== 8'h00) begin
            errors++;
            $display("FAIL reset_slave_data: got adr=%h dat=%h, required 000000/00", s_if.adr, s_if.dat_w);
        end
        checks++;
        if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack_err: got %b, required 0000", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err});
        end
        checks++;
        if (m0_if.dat_r !== 8'h00 || m1_if.dat_r !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got m0=%h m1=%h, required 00/00", m0_if.dat_r, m1_if.dat_r);
        end
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        s_if.ack = 1'b0;
        s_if.dat_r = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_write;
        xfer(0, 1'b1, 24'h010123, 8'h5A, 8'h3C, 2, 1);
        set_cyc(0, 1'b0);
        @(negedge clk);
        checks++;
        if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0 || m1_if.err !== 1'b0 || m1_if.dat_r !== 8'h00) begin
            errors++;
            $display("FAIL write_after: got m0_ack=%b m1_ack=%b m1_err=%b m1_dat=%h, required all 0",
                     m0_if.ack, m1_if.ack, m1_if.err, m1_if.dat_r);
        end
        tick(2);
    endtask

    task automatic test_contention;
        apply_reset();
        drive_m(1, 1'b1, 1'b1, 1'b0, 24'h200000, 8'h00);
        xfer(0, 1'b0, 24'h100000, 8'h00, 8'h81, 1, 1);
        set_cyc(0, 1'b0);
        xfer(1, 1'b0, 24'h200000, 8'h00, 8'h92, 0, 2);
        set_cyc(1, 1'b0);
        tick(2);
        drive_m(1, 1'b1, 1'b1, 1'b0, 24'h200004, 8'h00);
        xfer(0, 1'b0, 24'h100004, 8'h00, 8'h83, 1, 1);
        set_cyc(0, 1'b0);
        xfer(1, 1'b0, 24'h200004, 8'h00, 8'h94, 1, 2);
        set_cyc(1, 1'b0);
        tick(2);
    endtask

    task automatic test_bus_lock;
        xfer(1, 1'b0, 24'h300001, 8'h00, 8'h11, 1, 1);
        drive_m(0, 1'b1, 1'b1, 1'b0, 24'h000040, 8'h00);
        xfer(1, 1'b0, 24'h300002, 8'h00, 8'h22, 0, 0);
        xfer(1, 1'b0, 24'h300003, 8'h00, 8'h33, 1, 0);
        set_cyc(1, 1'b0);
        xfer(0, 1'b0, 24'h000040, 8'h00, 8'h44, 0, 2);
        set_cyc(0, 1'b0);
        tick(2);
    endtask

    task automatic test_timeout;
        int n;
        bit seen;
        drive_m(0, 1'b1, 1'b1, 1'b0, 24'h0000F0, 8'h00);
        n = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (m0_if.err === 1'b1) seen = 1'b1;
            else if (s_if.stb === 1'b1) n++;
        end
        checks++;
        if (!seen || n != 4) begin
            errors++;
            $display("FAIL timeout_stalls: got err_seen=%0d after %0d stall cycles, required err after 4", seen, n);
        end
        checks++;
        if (s_if.stb !== 1'b0 || m0_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: got s_stb=%b ack=%b, required 0/0", s_if.stb, m0_if.ack);
        end
        @(negedge clk);
        checks++;
        if (m0_if.err !== 1'b0 || s_if.stb !== 1'b1 || s_if.cyc !== 1'b1) begin
            errors++;
            $display("FAIL after_abort: got err=%b s_stb=%b s_cyc=%b, required 0/1/1", m0_if.err, s_if.stb, s_if.cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (m0_if.err !== 1'b0 || s_if.stb !== 1'b1) begin
            errors++;
            $display("FAIL fresh_count: got err=%b s_stb=%b on 4th new stall, required 0/1", m0_if.err, s_if.stb);
        end
        @(negedge clk);
        s_if.ack = 1'b1;
        #1;
        checks++;
        if (m0_if.err !== 1'b1 || m0_if.ack !== 1'b0 || s_if.stb !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: got err=%b ack=%b s_stb=%b, required 1/0/0", m0_if.err, m0_if.ack, s_if.stb);
        end
        @(posedge clk);
        #1;
        s_if.ack = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        tick(2);
    endtask

    task automatic test_async_reset;
        drive_m(1, 1'b1, 1'b1, 1'b1, 24'hABCDEF, 8'h77);
        s_if.dat_r = 8'h55;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_if.stb !== 1'b1 || s_if.adr !== 24'hABCDEF) begin
            errors++;
            $display("FAIL own1_before_reset: got s_stb=%b adr=%h, required 1/abcdef", s_if.stb, s_if.adr);
        end
        #2;
        s_if.ack = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b000 || s_if.adr !== 24'h000000 || s_if.dat_w !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_slave: got cyc/stb/we=%b adr=%h dat=%h, required 0",
                     {s_if.cyc, s_if.stb, s_if.we}, s_if.adr, s_if.dat_w);
        end
        checks++;
        if ({m1_if.ack, m1_if.err} !== 2'b00 || m1_if.dat_r !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_m1: got ack/err=%b dat=%h, required 00/00", {m1_if.ack, m1_if.err}, m1_if.dat_r);
        end
        reset_n = 1'b1;
        s_if.ack = 1'b0;
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 24'h000123, 8'h00, 8'hC3, 1, 1);
        set_cyc(0, 1'b0);
        tick(2);
    endtask

    initial begin
        reset_n = 1'b1;
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        s_if.ack   = 1'b0;
        s_if.dat_r = 8'h00;
        s_if.err   = 1'b0;
        test_reset();
        test_single_write();
        test_contention();
        test_bus_lock();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
